// File: rtl/gnn_0_example_axi_read_master_pkg.sv
// Shared FSM encoding, beat/page constants and helpers for the AXI4 read master.
package gnn_0_example_axi_read_master_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned BeatBytes     = 64;
    localparam int unsigned BeatBytesLog2 = 6;
    localparam int unsigned PageBeats     = 64;

    function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/gnn_0_example_axi_read_master_if.sv
// AXI4 read-channel and output-stream signals of the read master.
interface gnn_0_example_axi_read_master_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 512
);
    logic                 m_axi_arvalid;
    logic                 m_axi_arready;
    logic [AddrWidth-1:0] m_axi_araddr;
    logic [7:0]           m_axi_arlen;
    logic                 m_axi_rvalid;
    logic                 m_axi_rready;
    logic [DataWidth-1:0] m_axi_rdata;
    logic                 m_axi_rlast;
    logic                 data_tvalid;
    logic                 data_tready;
    logic                 data_tlast;
    logic [DataWidth-1:0] data_tdata;

    modport master (
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
               data_tvalid, data_tlast, data_tdata,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, data_tready
    );

    modport slave (
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
               data_tvalid, data_tlast, data_tdata,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, data_tready
    );

endinterface

// File: rtl/gnn_0_example_axi_read_master_axi_burst_calc.sv
// Burst sizing: next burst length from the registered address / remaining-beats pair,
// which advances on every AR handshake.
module gnn_0_example_axi_read_master_axi_burst_calc
    import gnn_0_example_axi_read_master_pkg::*;
#(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned CountWidth  = 32,
    parameter int unsigned MaxBurstLen = 16,
    localparam int unsigned LenWidth   = $clog2(MaxBurstLen + 1)
) (
    input  logic                  kernel_clk,
    input  logic                  kernel_rst,
    input  logic                  load_i,
    input  logic [AddrWidth-1:0]  load_addr_i,
    input  logic [CountWidth-1:0] load_beats_i,
    input  logic                  advance_i,
    output logic [AddrWidth-1:0]  addr_o,
    output logic [CountWidth-1:0] remaining_o,
    output logic [LenWidth-1:0]   len_o
);

    logic [AddrWidth-1:0]  addr_q;
    logic [CountWidth-1:0] remaining_q;
    logic [CountWidth-1:0] page_room;
    logic [CountWidth-1:0] burst;

    // Beats left before the next 4 KB page boundary; never zero.
    assign page_room = CountWidth'(PageBeats) - CountWidth'(addr_q[11:BeatBytesLog2]);
    assign burst     = CountWidth'(min3(32'(remaining_q), 32'(MaxBurstLen), 32'(page_room)));

    assign addr_o      = addr_q;
    assign remaining_o = remaining_q;
    assign len_o       = LenWidth'(burst);

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (load_i) begin
            addr_q      <= load_addr_i;
            remaining_q <= load_beats_i;
        end else if (advance_i) begin
            addr_q      <= addr_q + (AddrWidth'(burst) << BeatBytesLog2);
            remaining_q <= remaining_q - burst;
        end
    end

endmodule

// File: rtl/gnn_0_example_axi_read_master.sv
// AXI4 read master: splits a (start address, byte count) request into AR bursts and
// forwards the R data as a 512-bit stream with tlast on the final beat.
module gnn_0_example_axi_read_master
    import gnn_0_example_axi_read_master_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_MAX_BURST_LEN    = 16,
    parameter int unsigned C_MAX_OUTSTANDING  = 4
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst,
    input  logic                          read_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] xfer_start_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_in_bytes,
    output logic                          read_done,
    gnn_0_example_axi_read_master_if.master bus
);

    localparam int unsigned OutWidth = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int unsigned LenWidth = $clog2(C_MAX_BURST_LEN + 1);

    state_e                        state_q;
    logic [C_XFER_SIZE_WIDTH-1:0]  total_q;
    logic [C_XFER_SIZE_WIDTH-1:0]  rx_cnt_q;
    logic [C_XFER_SIZE_WIDTH-1:0]  start_beats;
    logic [C_XFER_SIZE_WIDTH-1:0]  remaining;
    logic [OutWidth-1:0]           outstanding_q;
    logic [LenWidth-1:0]           burst_len;
    logic [C_M_AXI_ADDR_WIDTH-1:0] burst_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata;
    logic                          active;
    logic                          load;
    logic                          arvalid;
    logic                          rready;
    logic                          tvalid;
    logic                          ar_hs;
    logic                          r_hs;
    logic                          r_last_hs;
    logic                          last_ar;

    assign start_beats = xfer_size_in_bytes >> BeatBytesLog2;
    assign load        = (state_q == StIdle) && read_start;
    assign active      = (state_q == StIssue) || (state_q == StDrain);

    // Depends only on registers, so address/length stay put until the slave accepts.
    assign arvalid = (state_q == StIssue) && (remaining != '0) &&
                     (outstanding_q < OutWidth'(C_MAX_OUTSTANDING));
    assign rready  = bus.data_tready && active;
    assign tvalid  = bus.m_axi_rvalid && active;
    assign rdata   = bus.m_axi_rdata;

    assign ar_hs     = arvalid && bus.m_axi_arready;
    assign r_hs      = bus.m_axi_rvalid && rready;
    assign r_last_hs = r_hs && bus.m_axi_rlast;
    assign last_ar   = ar_hs && (C_XFER_SIZE_WIDTH'(burst_len) == remaining);

    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_araddr  = burst_addr;
    assign bus.m_axi_arlen   = arvalid ? 8'(burst_len - 1'b1) : 8'd0;
    assign bus.m_axi_rready  = rready;
    assign bus.data_tvalid   = tvalid;
    assign bus.data_tdata    = rdata;
    assign bus.data_tlast    = tvalid && (rx_cnt_q == total_q - 1'b1);

    gnn_0_example_axi_read_master_axi_burst_calc #(
        .AddrWidth   (C_M_AXI_ADDR_WIDTH),
        .CountWidth  (C_XFER_SIZE_WIDTH),
        .MaxBurstLen (C_MAX_BURST_LEN)
    ) u_burst_calc (
        .kernel_clk   (kernel_clk),
        .kernel_rst   (kernel_rst),
        .load_i       (load),
        .load_addr_i  (xfer_start_addr),
        .load_beats_i (start_beats),
        .advance_i    (ar_hs),
        .addr_o       (burst_addr),
        .remaining_o  (remaining),
        .len_o        (burst_len)
    );

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state_q       <= StIdle;
            total_q       <= '0;
            rx_cnt_q      <= '0;
            outstanding_q <= '0;
            read_done     <= 1'b0;
        end else begin
            read_done <= 1'b0;

            case ({ar_hs, r_last_hs})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: ;
            endcase

            if (r_hs) begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (read_start) begin
                        total_q       <= start_beats;
                        rx_cnt_q      <= '0;
                        outstanding_q <= '0;
                        if (start_beats == '0) begin
                            state_q   <= StDone;
                            read_done <= 1'b1;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (last_ar) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if ((rx_cnt_q == total_q) || (r_hs && (rx_cnt_q + 1'b1 == total_q))) begin
                        state_q   <= StDone;
                        read_done <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_0_example_axi_read_master.sv
// Bench for the AXI4 read master: AXI slave/memory model, stream monitor and directed plus
// randomized transfers checked against a burst/beat list computed from the transfer rules.
module tb_gnn_0_example_axi_read_master;

    logic         kernel_clk = 1'b0;
    logic         kernel_rst;
    logic         read_start;
    logic [63:0]  xfer_start_addr;
    logic [31:0]  xfer_size_in_bytes;
    logic         read_done;

    gnn_0_example_axi_read_master_if #(.AddrWidth(64), .DataWidth(512)) bus ();

    gnn_0_example_axi_read_master dut (
        .kernel_clk         (kernel_clk),
        .kernel_rst         (kernel_rst),
        .read_start         (read_start),
        .xfer_start_addr    (xfer_start_addr),
        .xfer_size_in_bytes (xfer_size_in_bytes),
        .read_done          (read_done),
        .bus                (bus)
    );

    always #5 kernel_clk = ~kernel_clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] rdy;
        logic        last;
    } beat_t;

    int checks = 0;
    int errors = 0;

    beat_t        rq[$];
    logic [63:0]  ar_addr_log[$];
    logic [7:0]   ar_len_log[$];
    int           ar_rx_at[$];
    logic [511:0] beat_data_log[$];
    logic         beat_last_log[$];
    int cyc = 0, done_cnt = 0, done_cyc = -1, last_beat_cyc = -1, first_arv_cyc = -1;
    int rlast_cnt = 0, ar_wait = 0, ar_mode = 0, t_mode = 0;
    bit r_hold = 1'b0, stab_pend = 1'b0, mirror_chk = 1'b0;
    logic [63:0] stab_addr;
    logic [7:0]  stab_len;
    logic [31:0] seed = 32'h1234_5678;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mem_word(input logic [63:0] a, input logic [31:0] s);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = a[31:0] ^ (s + 32'(i) * 32'h9E37_79B9);
        return w;
    endfunction

    // AXI slave with R latency, plus monitor; drives on negedge, observes 1 ns later.
    always begin
        @(negedge kernel_clk);
        cyc++;
        if (ar_mode == 0)      bus.m_axi_arready = 1'b1;
        else if (ar_mode == 1) bus.m_axi_arready = (ar_wait >= 3);
        else                   bus.m_axi_arready = 1'($urandom_range(0, 1));
        if (!r_hold && rq.size() > 0 && cyc >= int'(rq[0].rdy)) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = mem_word(rq[0].addr, seed);
            bus.m_axi_rlast  = rq[0].last;
        end else begin
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rdata  = '0;
            bus.m_axi_rlast  = 1'b0;
        end
        if (t_mode == 0)      bus.data_tready = 1'b1;
        else if (t_mode == 1) bus.data_tready = ((cyc % 2) == 1);
        else                  bus.data_tready = ($urandom_range(0, 3) != 0);
        #1;
        if (kernel_rst) begin
            ar_wait   = 0;
            stab_pend = 1'b0;
        end else begin
            if (stab_pend) begin
                check("ar_hold_valid", bus.m_axi_arvalid, 1'b1);
                check("ar_hold_addr", bus.m_axi_araddr, stab_addr);
                check("ar_hold_len", bus.m_axi_arlen, stab_len);
            end
            stab_pend = 1'b0;
            if (bus.m_axi_arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                check("ar_outstanding", (ar_addr_log.size() - rlast_cnt) < 4, 1'b1);
                ar_addr_log.push_back(bus.m_axi_araddr);
                ar_len_log.push_back(bus.m_axi_arlen);
                ar_rx_at.push_back(beat_data_log.size());
                for (int k = 0; k <= int'(bus.m_axi_arlen); k++)
                    rq.push_back('{addr: bus.m_axi_araddr + 64'(k * 64), rdy: 32'(cyc + 2),
                                   last: (k == int'(bus.m_axi_arlen))});
                ar_wait = 0;
            end else if (bus.m_axi_arvalid) begin
                ar_wait++;
                stab_pend = 1'b1;
                stab_addr = bus.m_axi_araddr;
                stab_len  = bus.m_axi_arlen;
            end
            if (mirror_chk) check("rready_mirror", bus.m_axi_rready, bus.data_tready);
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                void'(rq.pop_front());
                if (bus.m_axi_rlast) rlast_cnt++;
            end
            if (bus.data_tvalid && bus.data_tready) begin
                beat_data_log.push_back(bus.data_tdata);
                beat_last_log.push_back(bus.data_tlast);
                last_beat_cyc = cyc;
            end
            if (read_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_xfer(input logic [63:0] a, input int bytes, output int start_c);
        ar_addr_log.delete();
        ar_len_log.delete();
        ar_rx_at.delete();
        beat_data_log.delete();
        beat_last_log.delete();
        done_cnt = 0; done_cyc = -1; first_arv_cyc = -1; last_beat_cyc = -1; rlast_cnt = 0;
        seed = $urandom;
        @(negedge kernel_clk);
        read_start = 1'b1;
        xfer_start_addr = a;
        xfer_size_in_bytes = 32'(bytes);
        #2 start_c = cyc;
        @(negedge kernel_clk);
        read_start = 1'b0;
        xfer_start_addr = {$urandom, $urandom};
        xfer_size_in_bytes = $urandom;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge kernel_clk);
            #2 t++;
        end
        check({name, " done_seen"}, done_cnt != 0, 1'b1);
    endtask

    task automatic verify(input string name, input logic [63:0] a, input int bytes,
                          input int start_c);
        logic [63:0] ea[$];
        int el[$];
        logic [63:0] cur = a;
        int rem = bytes / 64;
        int beats = bytes / 64;
        int len;
        while (rem > 0) begin
            len = (rem > 16) ? 16 : rem;
            if (len > 64 - int'(cur[11:6])) len = 64 - int'(cur[11:6]);
            ea.push_back(cur);
            el.push_back(len);
            cur += 64'(len * 64);
            rem -= len;
        end
        repeat (3) @(negedge kernel_clk);
        #2;
        check({name, " ar_count"}, ar_addr_log.size(), ea.size());
        for (int i = 0; i < ea.size() && i < ar_addr_log.size(); i++) begin
            check($sformatf("%s ar%0d addr", name, i), ar_addr_log[i], ea[i]);
            check($sformatf("%s ar%0d len", name, i), ar_len_log[i], el[i] - 1);
        end
        check({name, " beat_count"}, beat_data_log.size(), beats);
        for (int k = 0; k < beats && k < beat_data_log.size(); k++) begin
            check($sformatf("%s beat%0d data", name, k), beat_data_log[k],
                  mem_word(a + 64'(k * 64), seed));
            check($sformatf("%s beat%0d tlast", name, k), beat_last_log[k], k == beats - 1);
        end
        check({name, " done_pulses"}, done_cnt, 1);
        if (beats == 0) begin
            check({name, " done_time"}, done_cyc, start_c + 1);
            check({name, " no_arvalid"}, first_arv_cyc, -1);
        end else begin
            check({name, " done_time"}, done_cyc, last_beat_cyc + 1);
            check({name, " first_arvalid"}, first_arv_cyc, start_c + 1);
        end
    endtask

    task automatic run_xfer(input logic [63:0] a, input int bytes, input string name);
        int sc;
        start_xfer(a, bytes, sc);
        wait_done(name);
        verify(name, a, bytes, sc);
    endtask

    initial begin
        int sc;
        int t;
        logic [63:0] ra;
        kernel_rst = 1'b1;
        read_start = 1'b0;
        xfer_start_addr = '0;
        xfer_size_in_bytes = '0;
        repeat (3) @(negedge kernel_clk);
        #2;
        check("rst arvalid", bus.m_axi_arvalid, 1'b0);
        check("rst araddr", bus.m_axi_araddr, 64'd0);
        check("rst arlen", bus.m_axi_arlen, 8'd0);
        check("rst rready", bus.m_axi_rready, 1'b0);
        check("rst tvalid", bus.data_tvalid, 1'b0);
        check("rst tlast", bus.data_tlast, 1'b0);
        check("rst read_done", read_done, 1'b0);
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        repeat (2) @(negedge kernel_clk);

        run_xfer(64'h0, 128, "t128");
        run_xfer(64'h0, 2048, "t2k");
        run_xfer(64'hFC0, 256, "t4kx");
        run_xfer(64'h40, 0, "tzero");

        // Outstanding limit: R held off until four bursts are in flight.
        r_hold = 1'b1;
        start_xfer(64'h0, 5120, sc);
        t = 0;
        while (ar_addr_log.size() < 4 && t < 200) begin
            @(negedge kernel_clk);
            #2 t++;
        end
        repeat (10) @(negedge kernel_clk);
        #2;
        check("ost ar_count_held", ar_addr_log.size(), 4);
        check("ost arvalid_low", bus.m_axi_arvalid, 1'b0);
        r_hold = 1'b0;
        wait_done("ost");
        check("ost fifth_ar_after_rlast", ar_rx_at.size() > 4 && ar_rx_at[4] >= 16, 1'b1);
        verify("ost", 64'h0, 5120, sc);

        // Backpressure, slow arready, and an ignored mid-transfer request.
        ar_mode = 1;
        t_mode = 1;
        start_xfer(64'h2000, 1024, sc);
        mirror_chk = 1'b1;
        t = 0;
        while (beat_data_log.size() < 4 && t < 300) begin
            @(negedge kernel_clk);
            #2 t++;
        end
        @(negedge kernel_clk);
        read_start = 1'b1;
        xfer_start_addr = 64'h8000;
        xfer_size_in_bytes = 32'd128;
        @(negedge kernel_clk);
        read_start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 300) begin
            if (beat_data_log.size() == 16) mirror_chk = 1'b0;
            @(negedge kernel_clk);
            #2 t++;
        end
        mirror_chk = 1'b0;
        check("bp done_seen", done_cnt != 0, 1'b1);
        verify("bp", 64'h2000, 1024, sc);
        ar_mode = 0;
        t_mode = 0;

        // Reset in the middle of a transfer, then a fresh request.
        start_xfer(64'h0, 2048, sc);
        t = 0;
        while (beat_data_log.size() < 5 && t < 300) begin
            @(negedge kernel_clk);
            #2 t++;
        end
        @(negedge kernel_clk);
        kernel_rst = 1'b1;
        #2;
        rq.delete();
        check("mrst arvalid", bus.m_axi_arvalid, 1'b0);
        check("mrst arlen", bus.m_axi_arlen, 8'd0);
        check("mrst araddr", bus.m_axi_araddr, 64'd0);
        check("mrst rready", bus.m_axi_rready, 1'b0);
        check("mrst tvalid", bus.data_tvalid, 1'b0);
        check("mrst tlast", bus.data_tlast, 1'b0);
        check("mrst read_done", read_done, 1'b0);
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        repeat (2) @(negedge kernel_clk);
        run_xfer(64'h3000, 128, "post_rst");

        // Randomized transfers near page ends with random arready / tready.
        ar_mode = 2;
        t_mode = 2;
        for (int n = 0; n < 4; n++) begin
            ra = 64'($urandom_range(0, 15)) * 64'd4096 + 64'($urandom_range(40, 63)) * 64'd64;
            run_xfer(ra, $urandom_range(1, 40) * 64, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnn_0_example_axi_read_master.md
# gnn_0_example_axi_read_master

AXI4 read master that turns a (start address, byte count) request from the bias loader into AXI4 read bursts and returns the data as a 512-bit stream. It sits directly upstream of `gnn_0_example_bias`. That block drives `read_start` and the transfer descriptor, and consumes `data_t*`. The block is reusable by any loader that uses the same request/stream handshake.

## Interface
- C_M_AXI_ADDR_WIDTH, 64, AXI address width
- C_M_AXI_DATA_WIDTH, 512, AXI/stream data width (64 bytes per beat)
- C_XFER_SIZE_WIDTH, 32, byte-count width
- C_MAX_BURST_LEN, 16, max beats per AR (arlen ≤ 15)
- C_MAX_OUTSTANDING, 4, max AR bursts issued without their rlast
- kernel_clk  in  1  clock
- kernel_rst  in  1  reset: asynchronous, active-high; clock is kernel_clk
- read_start  in  1  one-cycle request pulse; descriptor sampled on this cycle
- xfer_start_addr  in  64  byte address, 64-byte aligned
- xfer_size_in_bytes  in  32  byte count, multiple of 64
- read_done  out  1  one-cycle pulse, transfer complete
- m_axi_arvalid / m_axi_arready  out / in  1 / 1  AR handshake
- m_axi_araddr  out  64  burst address
- m_axi_arlen  out  8  beats−1
- m_axi_rvalid / m_axi_rready  in / out  1 / 1  R handshake
- m_axi_rdata  in  512  read data
- m_axi_rlast  in  1  last beat of a burst
- data_tvalid / data_tready  out / in  1 / 1  stream handshake
- data_tlast  out  1  final beat of the whole transfer
- data_tdata  out  512  stream data

## Operation
- FSM states:
  - IDLE: on `read_start`, latch addr, total beats = size>>6 and beats remaining = size>>6. If size==0, go to DONE; otherwise go to ISSUE.
  - ISSUE: issue AR bursts until all beats are requested, then go to DRAIN.
  - DRAIN: wait until the received-beat count equals total beats, then go to DONE.
  - DONE: assert `read_done` for 1 cycle, then go to IDLE.
- `read_start` in any state other than IDLE is ignored.
- Burst length = min(beats remaining, C_MAX_BURST_LEN, 64 − addr[11:6]). No burst crosses a 4 KB boundary.
- After each AR handshake:
  - addr += len×64
  - remaining −= len
- Outstanding counter:
  - +1 on AR handshake; −1 on R handshake with rlast; both in the same cycle leaves it unchanged.
  - `arvalid` is held low while outstanding == C_MAX_OUTSTANDING.
- Data path is combinational pass-through:
  - data_tvalid = m_axi_rvalid & (state is ISSUE or DRAIN)
  - data_tdata = m_axi_rdata
  - m_axi_rready = data_tready & (state is ISSUE or DRAIN)
- A received-beat counter (32-bit) increments on each R handshake.
- data_tlast = data_tvalid & (received count == total − 1).
- RRESP is not checked. AXI IDs are all zero, and data returns in order.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0.
- `read_start` at cycle N: the first `arvalid` is asserted at N+1.
- While `arvalid` is high and `arready` is low, `araddr` and `arlen` are held stable. `arvalid` is never dropped without a handshake.
- Back-to-back ARs are allowed: `arvalid` may stay high in the cycle after a handshake, carrying the next burst.
- The last stream beat is accepted at cycle M: state DONE at M+1 with `read_done` = 1; IDLE at M+2.
- Zero-byte request at N: `read_done` = 1 at N+1, and no AR is issued.
- Stream latency equals AXI R latency (0 added cycles). Backpressure from `data_tready` propagates to `rready` in the same cycle.
- Reset mid-transfer: immediate return to IDLE with outputs 0. Outstanding AXI transactions are abandoned; the interconnect is reset by the same system reset.

## Structure
- Shared package holds:
  - FSM state encoding (2 bits: IDLE/ISSUE/DRAIN/DONE)
  - beat-bytes constant 64 and its log2 (6)
  - 4 KB page-beats constant (64)
- One natural sub-module, `axi_burst_calc`: combinational length computation plus a registered next-address / remaining-beats pair. Everything else lives in the top module.

## Test plan
- 128 B at 0x0, arready=1, R with 2-cycle latency, tready=1 → one AR (araddr 0x0, arlen 1); 2 beats with tlast on the 2nd; `read_done` pulses 1 cycle after the 2nd beat.
- 2048 B at 0x0 → ARs (0x0, arlen 15) then (0x400, arlen 15); 32 beats; tlast only on beat 32.
- 4 KB crossing: 256 B at 0xFC0 → ARs (0xFC0, arlen 0) then (0x1000, arlen 2); 4 beats.
- Outstanding limit: 5120 B, arready=1, rvalid held 0 → exactly 4 ARs then `arvalid` low. After one rlast, a 5th AR is issued; `read_done` after 80 beats.
- Backpressure: 1024 B, tready toggling 1/0 every cycle, arready delayed 3 cycles with `araddr` stable → rready mirrors tready; 16 beats delivered in order with tdata intact; a `read_start` pulse mid-transfer is ignored.
- Zero size → `read_done` at N+1, no `arvalid`. Reset asserted mid-transfer → all outputs 0 next cycle; a new 128 B request then completes normally.
